dmem_write_buffer: RTL and testbench
====================================

# dmem_write_buffer

Posted-write buffer between the CPU data port and the backing data memory/bus. CPU stores are accepted in one cycle into a DEPTH-entry FIFO and drained in order over a valid/ready handshake. CPU loads return the youngest buffered data for a matching word address, otherwise the backing memory's read data. A Stall output holds the CPU only when the buffer is full and cannot drain.

## Interface
- DEPTH, 4, number of buffered writes; must be a power of two, ≥2
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all buffer state
- MemWrite  in  1  CPU store request this cycle
- ALUResult  in  32  CPU data address, used for both stores and loads
- WriteData  in  32  CPU store data
- ReadData  out  32  load data returned to the CPU (combinational)
- Stall  out  1  store cannot be accepted this cycle; CPU must hold
- BusRData  in  32  backing-memory read data for address ALUResult (combinational)
- BusValid  out  1  head entry is presented for drain
- BusReady  in  1  backing memory accepts the head entry this cycle
- BusAddr  out  32  head entry address
- BusWData  out  32  head entry data
- Count  out  $clog2(DEPTH+1)  number of valid entries
- Empty  out  1  Count == 0

## Operation
- Storage: DEPTH entries of {addr[31:0], data[31:0]}; head/tail pointers of $clog2(DEPTH) bits wrap modulo DEPTH; Count is held explicitly (0..DEPTH).
- Drain: BusValid = (Count != 0). BusAddr/BusWData = head entry. Pop = BusValid && BusReady.
- Enqueue: Push = MemWrite && !Stall. Writes {ALUResult, WriteData} at tail.
- Stall = MemWrite && (Count == DEPTH) && !BusReady. When full, a store is accepted in the same cycle that the head drains.
- Count update: Push && !Pop → +1; Pop && !Push → −1; both or neither → unchanged.
- Address is stored unmodified. All compares use bits [31:2], so byte offset is ignored.
- Forwarding: on every cycle, ReadData = data of the youngest valid entry whose addr[31:2] equals ALUResult[31:2]. If no entry matches, ReadData = BusRData.
- An entry being popped this cycle still participates in forwarding this cycle.
- A store being pushed this cycle does not participate in forwarding until the next cycle.
- No coalescing. Duplicate addresses occupy separate entries and drain in program order.
- Reset state: Count=0, Empty=1, BusValid=0, pointers=0, Stall=0. Entry contents are don't-care and are never visible while invalid.
- Reset during operation: all buffered writes are discarded. BusValid falls asynchronously with reset. Stall is 0 while reset is asserted.

## Timing
- Store accept: zero-wait when not stalled. An entry pushed at edge N is visible on BusValid/BusAddr in cycle N+1 if the buffer was empty.
- Forwarding latency: one cycle after the push edge.
- Throughput: one push and one pop per cycle, concurrently.
- Bus handshake: BusAddr/BusWData are stable while BusValid && !BusReady. BusValid never drops without a pop or a reset.
- Stall and ReadData are combinational from inputs and state. Count, Empty and BusValid come from registered state only.

## Test plan
- Single store: reset, then MemWrite with ALUResult=0x100, WriteData=0xDEADBEEF, BusReady=1 → next cycle BusValid=1, BusAddr=0x100, BusWData=0xDEADBEEF, Count=1. After the following edge, Empty=1 and BusValid=0.
- Full/stall: BusReady=0, stores to 0x0, 0x4, 0x8, 0xC → Count=4. A fifth store (0x10) gives Stall=1, and Count and contents are unchanged. Raising BusReady in the same cycle gives Stall=0: 0x0 pops, 0x10 pushes, Count stays 4.
- Forwarding: BusReady=0, stores 0x200=0x11, then 0x200=0x22, then 0x204=0x33.
  - Load 0x200 → ReadData=0x22.
  - Load 0x202 → 0x22.
  - Load 0x204 → 0x33.
  - Load 0x300 with BusRData=0xA5A5A5A5 → 0xA5A5A5A5.
- Wrap/order: 12 stores with incrementing data while BusReady toggles pseudo-randomly → bus sees all 12 in program order, no loss or duplication, and Count never exceeds 4.
- Simultaneous push/pop: at Count=2 with BusReady=1 and MemWrite=1 → Count remains 2, head advances, new entry is at tail.
- Async reset mid-drain: 3 entries buffered, BusReady=0, assert reset between edges → BusValid=0 and Count=0 immediately. After release, a load of a previously buffered address returns BusRData.

Source files
------------

// File: rtl/dmem_write_buffer.sv
// Posted-write buffer between the CPU data port and backing memory: stores enter a
// DEPTH-entry FIFO and drain in order; loads forward the youngest buffered match.
module dmem_write_buffer #(
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          MemWrite,
   input  logic [31:0]   ALUResult,
   input  logic [31:0]   WriteData,
   output logic [31:0]   ReadData,
   output logic          Stall,
   input  logic [31:0]   BusRData,
   output logic          BusValid,
   input  logic          BusReady,
   output logic [31:0]   BusAddr,
   output logic [31:0]   BusWData,
   output logic [CW-1:0] Count,
   output logic          Empty
);

   logic [DEPTH-1:0][31:0] addr_q, data_q;
   logic [PW-1:0]          head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]          count_q, count_d;
   logic                   full, push, pop;
   logic [PW-1:0]          fwd_idx;
   logic [31:0]            rdata;

   assign full     = (count_q == CW'(DEPTH));
   assign BusValid = (count_q != '0);
   assign Empty    = (count_q == '0);
   assign Count    = count_q;
   assign BusAddr  = addr_q[head_q];
   assign BusWData = data_q[head_q];

   // A full buffer still accepts a store in the cycle its head drains.
   assign Stall = MemWrite && full && !BusReady;
   assign push  = MemWrite && !Stall;
   assign pop   = BusValid && BusReady;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (pop)  head_d = head_q + PW'(1);
      if (push) tail_d = tail_q + PW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry payload needs no reset: it is never observed while invalid.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[tail_q] <= ALUResult;
         data_q[tail_q] <= WriteData;
      end
   end

   // Walk oldest to youngest so the last valid match wins.
   always_comb begin
      rdata   = BusRData;
      fwd_idx = head_q;
      for (int i = 0; i < DEPTH; i++) begin
         fwd_idx = head_q + PW'(i);
         if ((CW'(i) < count_q) && (addr_q[fwd_idx][31:2] == ALUResult[31:2]))
            rdata = data_q[fwd_idx];
      end
   end

   assign ReadData = rdata;

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Directed bench for dmem_write_buffer: store/drain, full stall, forwarding,
// concurrent push/pop, ordered drain under a toggling BusReady, async reset.
module tb_dmem_write_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemWrite;
   logic [31:0] ALUResult, WriteData, ReadData, BusRData, BusAddr, BusWData;
   logic        Stall, BusValid, BusReady, Empty;
   logic [2:0]  Count;

   int n_cmp = 0;
   int n_bad = 0;

   dmem_write_buffer #(.DEPTH(4)) dut (
      .clk(clk), .reset(reset), .MemWrite(MemWrite), .ALUResult(ALUResult),
      .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall), .BusRData(BusRData),
      .BusValid(BusValid), .BusReady(BusReady), .BusAddr(BusAddr), .BusWData(BusWData),
      .Count(Count), .Empty(Empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      MemWrite = 1'b1; ALUResult = a; WriteData = d;
      tick();
      MemWrite = 1'b0;
   endtask

   initial begin
      logic [31:0] pat;
      int sent, rx, cyc;
      reset = 1'b1; MemWrite = 1'b0; ALUResult = '0; WriteData = '0;
      BusRData = '0; BusReady = 1'b0;
      #12;
      chk("rst_count", 32'(Count), 32'd0);
      chk("rst_empty", 32'(Empty), 32'd1);
      chk("rst_valid", 32'(BusValid), 32'd0);
      MemWrite = 1'b1;
      #1 chk("rst_stall", 32'(Stall), 32'd0);
      MemWrite = 1'b0;
      reset = 1'b0;
      tick();

      // single store, drained immediately
      BusReady = 1'b1;
      store(32'h100, 32'hDEADBEEF);
      chk("s_valid", 32'(BusValid), 32'd1);
      chk("s_addr",  BusAddr, 32'h100);
      chk("s_wdata", BusWData, 32'hDEADBEEF);
      chk("s_count", 32'(Count), 32'd1);
      tick();
      chk("s_empty", 32'(Empty), 32'd1);
      chk("s_valid0", 32'(BusValid), 32'd0);

      // fill, stall, then push-while-pop at full
      BusReady = 1'b0;
      for (int i = 0; i < 4; i++) store(32'(4 * i), 32'hA0 + 32'(i));
      chk("f_count", 32'(Count), 32'd4);
      MemWrite = 1'b1; ALUResult = 32'h10; WriteData = 32'hA4;
      #1 chk("f_stall", 32'(Stall), 32'd1);
      tick();
      chk("f_count_hold", 32'(Count), 32'd4);
      chk("f_head_hold", BusAddr, 32'h0);
      BusReady = 1'b1;
      #1 chk("f_stall_rdy", 32'(Stall), 32'd0);
      tick();
      MemWrite = 1'b0;
      chk("f_count_pp", 32'(Count), 32'd4);
      for (int i = 1; i <= 4; i++) begin
         chk("f_drain_addr", BusAddr, 32'(4 * i));
         chk("f_drain_data", BusWData, 32'hA0 + 32'(i));
         tick();
      end
      chk("f_empty", 32'(Empty), 32'd1);

      // forwarding
      BusReady = 1'b0;
      store(32'h200, 32'h11);
      store(32'h200, 32'h22);
      store(32'h204, 32'h33);
      BusRData = 32'hA5A5A5A5;
      ALUResult = 32'h200; #1 chk("fw_200", ReadData, 32'h22);
      ALUResult = 32'h202; #1 chk("fw_202", ReadData, 32'h22);
      ALUResult = 32'h204; #1 chk("fw_204", ReadData, 32'h33);
      ALUResult = 32'h300; #1 chk("fw_miss", ReadData, 32'hA5A5A5A5);
      MemWrite = 1'b1; ALUResult = 32'h208; WriteData = 32'h44;
      #1 chk("fw_push_same_cyc", ReadData, 32'hA5A5A5A5);
      tick();
      MemWrite = 1'b0;
      #1 chk("fw_push_next", ReadData, 32'h44);

      // async reset between edges discards all entries
      #2 reset = 1'b1;
      #1;
      chk("ar_valid", 32'(BusValid), 32'd0);
      chk("ar_count", 32'(Count), 32'd0);
      BusRData = 32'h77; ALUResult = 32'h200;
      #1 chk("ar_fwd", ReadData, 32'h77);
      tick();
      reset = 1'b0;
      tick();
      chk("ar_fwd_after", ReadData, 32'h77);

      // push and pop in the same cycle at Count=2
      store(32'h400, 32'h1);
      store(32'h404, 32'h2);
      chk("pp_count2", 32'(Count), 32'd2);
      BusReady = 1'b1;
      store(32'h408, 32'h3);
      chk("pp_count", 32'(Count), 32'd2);
      chk("pp_head", BusAddr, 32'h404);
      tick();
      chk("pp_tail_addr", BusAddr, 32'h408);
      chk("pp_tail_data", BusWData, 32'h3);
      tick();
      chk("pp_empty", 32'(Empty), 32'd1);

      // 12 stores in order against a toggling BusReady
      pat = 32'h5A3C_96E1;
      sent = 0; rx = 0; cyc = 0;
      while ((sent < 12 || BusValid) && cyc < 200) begin
         BusReady  = pat[cyc % 32];
         MemWrite  = (sent < 12);
         ALUResult = 32'h1000 + 32'(4 * sent);
         WriteData = 32'(sent + 1);
         #1;
         if (BusValid && BusReady) begin
            chk("wr_order", BusWData, 32'(rx + 1));
            rx++;
         end
         if (MemWrite && !Stall) sent++;
         chk("wr_cnt_le4", 32'(Count > 3'd4), 32'd0);
         tick();
         cyc++;
      end
      MemWrite = 1'b0;
      chk("wr_no_timeout", 32'(cyc < 200), 32'd1);
      chk("wr_rx_total", 32'(rx), 32'd12);
      chk("wr_empty", 32'(Empty), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
